// File: rtl/mult_pkg.sv
// Shared constants for the radix-2 Booth multiplier.
// Holds the FSM state encoding and the default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: add/sub the multiplicand,
// then arithmetic-shift {A,Q,Q-1} right by one bit.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] q,
    input  logic           q_m1,
    input  logic [WIDTH:0] m,
    output logic [WIDTH:0] a_next,
    output logic [WIDTH:0] q_next,
    output logic           q_m1_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        case ({q[0], q_m1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        a_next    = {sum[WIDTH], sum[WIDTH:1]};
        q_next    = {sum[0], q[WIDTH:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_multiplier_n.sv
// Sequential radix-2 Booth multiplier, WIDTH+1 steps per operation.
// Define MULT_SIGNED_SEL_EN to add the Sgn port (1=signed, 0=unsigned).
module booth_multiplier_n
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               St,
`ifdef MULT_SIGNED_SEL_EN
    input  logic               Sgn,
`endif
    input  logic [WIDTH-1:0]   Mtp,
    input  logic [WIDTH-1:0]   Mtc,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] STEPS = CW'(WIDTH + 1);

    state_t         state;
    logic [WIDTH:0] acc;
    logic [WIDTH:0] q;
    logic [WIDTH:0] m;
    logic           q_m1;
    logic [CW-1:0]  cnt;

    logic [WIDTH:0] a_next;
    logic [WIDTH:0] q_next;
    logic           q_m1_next;
    logic           signed_mode;

`ifdef MULT_SIGNED_SEL_EN
    assign signed_mode = Sgn;
`else
    assign signed_mode = 1'b1;
`endif

    // The extra top bit gives -M headroom for the most-negative operand.
    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v,
                                           input logic s);
        return {s & v[WIDTH-1], v};
    endfunction

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a         (acc),
        .q         (q),
        .q_m1      (q_m1),
        .m         (m),
        .a_next    (a_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Product <= '0;
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (St) begin
                        m     <= ext(Mtc, signed_mode);
                        q     <= ext(Mtp, signed_mode);
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= STEPS;
                        Busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc  <= a_next;
                    q    <= q_next;
                    q_m1 <= q_m1_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        Product <= {a_next[WIDTH-2:0], q_next};
                        Done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier_n.sv
// Randomized self-checking bench for booth_multiplier_n (WIDTH=16).
// Builds with or without MULT_SIGNED_SEL_EN.
module tb_booth_multiplier_n;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           St;
    logic           Sgn;
    logic [W-1:0]   Mtp;
    logic [W-1:0]   Mtc;
    logic           Busy;
    logic           Done;
    logic [2*W-1:0] Product;

    int             errs   = 0;
    int             checks = 0;
    logic [2*W-1:0] last_prod;

    always #5 clk = ~clk;

    booth_multiplier_n #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .St      (St),
`ifdef MULT_SIGNED_SEL_EN
        .Sgn     (Sgn),
`endif
        .Mtp     (Mtp),
        .Mtc     (Mtc),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic s);
        longint     x;
        longint     y;
        logic [63:0] p;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        p = 64'(x * y);
        return p[2*W-1:0];
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [2*W-1:0] exp,
                         input logic mid);
        int n;
        @(negedge clk);
        Mtp = a;
        Mtc = b;
        Sgn = s;
        St  = 1'b1;
        @(negedge clk);
        St = 1'b0;
        chk("busy_start", 64'(Busy), 64'd1);
        n = 0;
        while (!Done && n < 64) begin
            if (mid && n == 3) begin
                Mtp = W'($urandom);
                Mtc = W'($urandom);
                Sgn = 1'($urandom);
                St  = 1'b1;
            end else begin
                St = 1'b0;
            end
            @(negedge clk);
            n++;
            if (n == 5) chk("prod_hold", 64'(Product), 64'(last_prod));
        end
        St  = 1'b0;
        Sgn = s;
        chk("latency", 64'(n), 64'(W + 1));
        chk("product", 64'(Product), 64'(exp));
        chk("busy_done", 64'(Busy), 64'd1);
        @(negedge clk);
        chk("done_pulse", 64'(Done), 64'd0);
        chk("busy_end", 64'(Busy), 64'd0);
        chk("prod_stable", 64'(Product), 64'(exp));
        last_prod = exp;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic         mid;
        int           dcount;

        rst = 1'b1;
        St  = 1'b0;
        Sgn = 1'b1;
        Mtp = '0;
        Mtc = '0;
        last_prod = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_prod", 64'(Product), 64'd0);
        rst = 1'b0;

        do_op(16'd3,    16'd3,    1'b1, 32'h0000_0009, 1'b0);
        do_op(16'hFFFD, 16'd3,    1'b1, 32'hFFFF_FFF7, 1'b0);
        do_op(16'd3,    16'hFFFD, 1'b1, 32'hFFFF_FFF7, 1'b0);
        do_op(16'hFFFD, 16'hFFFD, 1'b1, 32'h0000_0009, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1'b0);
        do_op(16'd0,    16'hFFF9, 1'b1, 32'h0000_0000, 1'b0);
`ifdef MULT_SIGNED_SEL_EN
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 1'b0);
`endif
        do_op(16'h1234, 16'h0056, 1'b1, 32'h0006_1d78, 1'b1);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0: a = 16'h8000;
                1: a = 16'h7FFF;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: b = 16'h8000;
                1: b = 16'hFFFF;
                default: b = W'($urandom);
            endcase
`ifdef MULT_SIGNED_SEL_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b1;
`endif
            mid = ($urandom_range(0, 4) == 0);
            do_op(a, b, s, ref_mul(a, b, s), mid);
        end

        @(negedge clk);
        Mtp = 16'h1111;
        Mtc = 16'h2222;
        Sgn = 1'b1;
        St  = 1'b1;
        @(negedge clk);
        St = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_done", 64'(Done), 64'd0);
        chk("abort_prod", 64'(Product), 64'd0);
        chk("abort_busy", 64'(Busy), 64'd0);
        last_prod = '0;
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (Done) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'd0);
        do_op(16'd7, 16'd7, 1'b1, 32'h0000_0031, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
